// File: rtl/hyp_func_unit_pipe_if.sv
// Handshake and lane-data bundle for the pipelined hyperbolic functional unit.
// Names are seen from the unit: i* signals flow into it, o* signals flow out.
interface hyp_func_unit_pipe_if #(
  parameter int DWIDTH = 16,
  parameter int NLANES = 4,
  parameter int SHW    = $clog2(DWIDTH) + 1
);
  logic                     iValid;
  logic                     oReady;
  logic [NLANES*DWIDTH-1:0] iData1;
  logic [NLANES*DWIDTH-1:0] iData2;
  logic [SHW-1:0]           iShift;
  logic [NLANES-1:0]        iSign;
  logic [NLANES-1:0]        compin;
  logic                     scomp;
  logic                     oValid;
  logic                     iReady;
  logic [NLANES*DWIDTH-1:0] oData;
  logic                     iClrOvf;
  logic                     oOvf;

  modport master (
    output iValid, iData1, iData2, iShift, iSign, compin, scomp, iReady, iClrOvf,
    input  oReady, oValid, oData, oOvf
  );

  modport slave (
    input  iValid, iData1, iData2, iShift, iSign, compin, scomp, iReady, iClrOvf,
    output oReady, oValid, oData, oOvf
  );
endinterface

// File: rtl/hyp_func_unit_pipe.sv
// Two-stage, multi-lane hyperbolic micro-rotation: a*cosh(2^-S) +/- b*sinh(2^-S)
// by shift-add, with lane bypass, optional saturation and a sticky overflow flag.
module hyp_func_unit_pipe #(
  parameter int DWIDTH   = 16,
  parameter int NLANES   = 4,
  parameter int SATURATE = 1,
  parameter int SHW      = $clog2(DWIDTH) + 1
) (
  input  logic                iClk,
  input  logic                iRstN,
  hyp_func_unit_pipe_if.slave bus
);
  localparam int IW = DWIDTH + 2;
  localparam int AW = SHW + 2;

  typedef logic signed [IW-1:0] wide_t;

  logic          adv1;
  logic          adv2;
  logic [AW-1:0] shS;
  logic [AW-1:0] shA;
  logic [AW-1:0] shB;

  wide_t acoshNew [NLANES];
  wide_t bsinhNew [NLANES];

  logic                     v1_q, v1_d;
  wide_t                    acosh_q [NLANES];
  wide_t                    acosh_d [NLANES];
  wide_t                    bsinh_q [NLANES];
  wide_t                    bsinh_d [NLANES];
  logic [NLANES*DWIDTH-1:0] a_q, a_d;
  logic [NLANES-1:0]        sign_q, sign_d;
  logic [NLANES-1:0]        comp_q, comp_d;

  logic                     v2_q, v2_d;
  logic [NLANES*DWIDTH-1:0] data_q, data_d;
  logic                     ovf_q, ovf_d;

  logic [NLANES*DWIDTH-1:0] result;
  logic [NLANES-1:0]        laneOvf;

  assign adv2 = ~v2_q | bus.iReady;
  assign adv1 = ~v1_q | adv2;

  // Shift amounts are widened so 3S+3 never wraps; >>> past the width sign-fills.
  assign shS = AW'(bus.iShift);
  assign shA = {shS[AW-2:0], 1'b0} + AW'(1);
  assign shB = shS + {shS[AW-2:0], 1'b0} + AW'(3);

  for (genvar k = 0; k < NLANES; k++) begin : gLane
    wide_t aW, bW, aSh, bSh1, bSh3, aQ, rW;

    assign aW   = {{2{bus.iData1[k*DWIDTH+DWIDTH-1]}}, bus.iData1[k*DWIDTH +: DWIDTH]};
    assign bW   = {{2{bus.iData2[k*DWIDTH+DWIDTH-1]}}, bus.iData2[k*DWIDTH +: DWIDTH]};
    assign aSh  = aW >>> shA;
    assign bSh1 = bW >>> shS;
    assign bSh3 = bus.scomp ? (bW >>> shB) : wide_t'(0);

    assign acoshNew[k] = aW + aSh;
    assign bsinhNew[k] = bSh1 + bSh3;

    assign aQ = {{2{a_q[k*DWIDTH+DWIDTH-1]}}, a_q[k*DWIDTH +: DWIDTH]};
    assign rW = comp_q[k] ? aQ
              : (sign_q[k] ? (acosh_q[k] - bsinh_q[k]) : (acosh_q[k] + bsinh_q[k]));

    // In range exactly when the bits above the DWIDTH sign bit all match it.
    assign laneOvf[k] = ~comp_q[k] & ~((&rW[IW-1:DWIDTH-1]) | ~(|rW[IW-1:DWIDTH-1]));

    if (SATURATE != 0) begin : gSat
      assign result[k*DWIDTH +: DWIDTH] = laneOvf[k]
        ? (rW[IW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}})
        : rW[DWIDTH-1:0];
    end else begin : gWrap
      assign result[k*DWIDTH +: DWIDTH] = rW[DWIDTH-1:0];
    end
  end

  always_comb begin
    v1_d    = v1_q;
    acosh_d = acosh_q;
    bsinh_d = bsinh_q;
    a_d     = a_q;
    sign_d  = sign_q;
    comp_d  = comp_q;
    v2_d    = v2_q;
    data_d  = data_q;
    ovf_d   = ovf_q & ~bus.iClrOvf;
    if (adv1) begin
      v1_d    = bus.iValid;
      acosh_d = acoshNew;
      bsinh_d = bsinhNew;
      a_d     = bus.iData1;
      sign_d  = bus.iSign;
      comp_d  = bus.compin;
    end
    // A real beat entering stage 2 with an overflowing lane beats a same-cycle clear.
    if (adv2) begin
      v2_d   = v1_q;
      data_d = result;
      if (v1_q && (|laneOvf)) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      sign_q <= '0;
      comp_q <= '0;
      v2_q   <= 1'b0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < NLANES; k++) begin
        acosh_q[k] <= '0;
        bsinh_q[k] <= '0;
      end
    end else begin
      v1_q    <= v1_d;
      acosh_q <= acosh_d;
      bsinh_q <= bsinh_d;
      a_q     <= a_d;
      sign_q  <= sign_d;
      comp_q  <= comp_d;
      v2_q    <= v2_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.oReady = adv1;
  assign bus.oValid = v2_q;
  assign bus.oData  = data_q;
  assign bus.oOvf   = ovf_q;
endmodule
